// File: rtl/traffic_pkg.sv
// Shared types and lamp encodings for the intersection phase sequencer.
// TRAFFIC_CTRL_PED_EN adds the pedestrian walk/flash states to the enum.
package traffic_pkg;

    localparam int unsigned LEN_W  = 5;
    localparam int unsigned LAMP_W = 3;

    localparam logic [LAMP_W-1:0] LAMP_RED = 3'b100;
    localparam logic [LAMP_W-1:0] LAMP_YEL = 3'b010;
    localparam logic [LAMP_W-1:0] LAMP_GRN = 3'b001;

`ifdef TRAFFIC_CTRL_PED_EN
    typedef enum logic [2:0] {
        MAIN_GO, MAIN_YEL, RED_A, SIDE_GO, SIDE_YEL, RED_B, PED_WALK, PED_FLASH
    } traffic_state_t;
`else
    typedef enum logic [2:0] {
        MAIN_GO, MAIN_YEL, RED_A, SIDE_GO, SIDE_YEL, RED_B
    } traffic_state_t;
`endif

    function automatic logic [LAMP_W-1:0] main_lamp_of(input traffic_state_t s);
        case (s)
            MAIN_GO:  main_lamp_of = LAMP_GRN;
            MAIN_YEL: main_lamp_of = LAMP_YEL;
            default:  main_lamp_of = LAMP_RED;
        endcase
    endfunction

    function automatic logic [LAMP_W-1:0] side_lamp_of(input traffic_state_t s);
        case (s)
            SIDE_GO:  side_lamp_of = LAMP_GRN;
            SIDE_YEL: side_lamp_of = LAMP_YEL;
            default:  side_lamp_of = LAMP_RED;
        endcase
    endfunction

endpackage

// File: rtl/traffic_req_latch.sv
// Sticky request flop: any cycle with set high latches it; set beats a coincident clear.
module traffic_req_latch (
    input  logic clk,
    input  logic reset,
    input  logic set,
    input  logic clr,
    output logic pend
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)   pend <= 1'b0;
        else if (set) pend <= 1'b1;
        else if (clr) pend <= 1'b0;
    end

endmodule

// File: rtl/traffic_ctrl.sv
// Two-road intersection phase sequencer driving an external timer.
// Define TRAFFIC_CTRL_PED_EN to build in the pedestrian walk/flash phases.
module traffic_ctrl
    import traffic_pkg::*;
#(
    parameter logic [LEN_W-1:0] MAIN_LEN  = 5'd20,
    parameter logic [LEN_W-1:0] SIDE_LEN  = 5'd10,
    parameter logic [LEN_W-1:0] YEL_LEN   = 5'd4,
    parameter logic [LEN_W-1:0] RED_LEN   = 5'd2,
    parameter logic [LEN_W-1:0] WALK_LEN  = 5'd8,
    parameter logic [LEN_W-1:0] FLASH_LEN = 5'd6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              side_req,
    input  logic              ped_req,
    input  logic              t_done,
    input  logic              t_flicker,
    output logic              t_start,
    output logic [LEN_W-1:0]  t_length,
    output logic [LAMP_W-1:0] main_lamp,
    output logic [LAMP_W-1:0] side_lamp,
    output logic              ped_walk
);

    traffic_state_t state;
    traffic_state_t next_state;
    logic           start_pend;
    logic           mask_d;
    logic           done_ok;
    logic           side_pend;
    logic           side_clr;
    logic           ped_hold;

    function automatic logic [LEN_W-1:0] phase_len(input traffic_state_t s);
        case (s)
            MAIN_GO:            phase_len = MAIN_LEN;
            SIDE_GO:            phase_len = SIDE_LEN;
            MAIN_YEL, SIDE_YEL: phase_len = YEL_LEN;
`ifdef TRAFFIC_CTRL_PED_EN
            PED_WALK:           phase_len = WALK_LEN;
            PED_FLASH:          phase_len = FLASH_LEN;
`endif
            default:            phase_len = RED_LEN;
        endcase
    endfunction

    // A done in the start cycle or the one after belongs to the previous phase.
    assign done_ok  = t_done && !t_start && !mask_d && !start_pend;
    assign side_clr = done_ok && (next_state == SIDE_GO);

    always_comb begin
        next_state = state;
        case (state)
            MAIN_GO:   if (side_pend || ped_hold) next_state = MAIN_YEL;
            MAIN_YEL:  next_state = RED_A;
            RED_A:     next_state = SIDE_GO;
            SIDE_GO:   next_state = SIDE_YEL;
            SIDE_YEL:  next_state = RED_B;
`ifdef TRAFFIC_CTRL_PED_EN
            RED_B:     next_state = ped_hold ? PED_WALK : MAIN_GO;
            PED_WALK:  next_state = PED_FLASH;
            PED_FLASH: next_state = MAIN_GO;
`else
            RED_B:     next_state = MAIN_GO;
`endif
            default:   next_state = RED_B;
        endcase
    end

    // Every taken done re-arms the timer, including a MAIN_GO re-entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= RED_B;
            start_pend <= 1'b1;
            t_start    <= 1'b0;
            t_length   <= RED_LEN;
            main_lamp  <= LAMP_RED;
            side_lamp  <= LAMP_RED;
            mask_d     <= 1'b0;
        end else begin
            mask_d     <= t_start;
            start_pend <= 1'b0;
            t_start    <= 1'b0;
            if (start_pend) begin
                t_start <= 1'b1;
            end else if (done_ok) begin
                state     <= next_state;
                t_start   <= 1'b1;
                t_length  <= phase_len(next_state);
                main_lamp <= main_lamp_of(next_state);
                side_lamp <= side_lamp_of(next_state);
            end
        end
    end

    traffic_req_latch u_side_req (
        .clk   (clk),
        .reset (reset),
        .set   (side_req),
        .clr   (side_clr),
        .pend  (side_pend)
    );

`ifdef TRAFFIC_CTRL_PED_EN
    logic ped_pend;
    logic ped_clr;
    logic walk_q;

    assign ped_clr  = done_ok && (next_state == PED_WALK);
    assign ped_hold = ped_pend;

    traffic_req_latch u_ped_req (
        .clk   (clk),
        .reset (reset),
        .set   (ped_req),
        .clr   (ped_clr),
        .pend  (ped_pend)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                      walk_q <= 1'b0;
        else if (done_ok && !start_pend) walk_q <= (next_state == PED_WALK);
    end

    // Flashing walk is the timer's flicker passed straight through.
    assign ped_walk = (state == PED_FLASH) ? t_flicker : walk_q;
`else
    logic unused_ok;

    assign ped_hold  = 1'b0;
    assign ped_walk  = 1'b0;
    assign unused_ok = ^{ped_req, t_flicker, WALK_LEN, FLASH_LEN};
`endif

endmodule

// File: tb/tb_traffic_ctrl.sv
// Scoreboard bench for traffic_ctrl with a behavioural timer model alongside.
module tb_traffic_ctrl;
    import traffic_pkg::*;

    typedef struct packed {
        logic [4:0] len;
        logic [2:0] ml;
        logic [2:0] sl;
        logic [1:0] pm;
    } phase_t;

    localparam phase_t P_MG = {5'd20, LAMP_GRN, LAMP_RED, 2'd0};
    localparam phase_t P_MY = {5'd4,  LAMP_YEL, LAMP_RED, 2'd0};
    localparam phase_t P_RA = {5'd2,  LAMP_RED, LAMP_RED, 2'd0};
    localparam phase_t P_SG = {5'd10, LAMP_RED, LAMP_GRN, 2'd0};
    localparam phase_t P_SY = {5'd4,  LAMP_RED, LAMP_YEL, 2'd0};
    localparam phase_t P_RB = {5'd2,  LAMP_RED, LAMP_RED, 2'd0};
    localparam phase_t P_PW = {5'd8,  LAMP_RED, LAMP_RED, 2'd1};
    localparam phase_t P_PF = {5'd6,  LAMP_RED, LAMP_RED, 2'd2};

    logic       clk;
    logic       reset;
    logic       side_req;
    logic       ped_req;
    logic       t_done;
    logic       t_flicker;
    logic       t_start;
    logic [4:0] t_length;
    logic [2:0] main_lamp;
    logic [2:0] side_lamp;
    logic       ped_walk;

    logic       stale_en;
    logic       start_d;
    logic       done_q;
    logic       run;
    logic [4:0] cnt;

    int     n_chk  = 0;
    int     n_pass = 0;
    phase_t sb_q[$];
    phase_t cur = P_RB;
    int     cyc = 0;
    int     prev_len = 0;
    logic   first = 1'b1;
    logic   prev_start = 1'b0;

    traffic_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .side_req  (side_req),
        .ped_req   (ped_req),
        .t_done    (t_done),
        .t_flicker (t_flicker),
        .t_start   (t_start),
        .t_length  (t_length),
        .main_lamp (main_lamp),
        .side_lamp (side_lamp),
        .ped_walk  (ped_walk)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Timer model: done pulses L+1 cycles after start; flicker toggles while running.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0; run <= 1'b0; done_q <= 1'b0; t_flicker <= 1'b0; start_d <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            start_d <= t_start;
            if (t_start) begin
                cnt <= t_length; run <= 1'b1; t_flicker <= 1'b0;
            end else if (run) begin
                t_flicker <= ~t_flicker;
                if (cnt <= 5'd1) begin
                    done_q <= 1'b1; run <= 1'b0;
                end else begin
                    cnt <= cnt - 5'd1;
                end
            end
        end
    end

    // Stale-done injection lands in the two cycles the DUT must ignore.
    assign t_done = done_q | (stale_en & (t_start | start_d));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    endtask

    task automatic push(input phase_t p);
        sb_q.push_back(p);
    endtask

    task automatic push_side_cycle();
        push(P_MY); push(P_RA); push(P_SG); push(P_SY); push(P_RB);
    endtask

    task automatic cyc_wait(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_drain(input string tag);
        int i;
        i = 0;
        while (sb_q.size() != 0 && i < 600) begin
            @(posedge clk); #2; i++;
        end
        check(tag, 32'(sb_q.size()), 32'd0);
    endtask

    task automatic wait_side_go(input string tag);
        int i;
        i = 0;
        while (side_lamp != LAMP_GRN && i < 200) begin
            @(posedge clk); #2; i++;
        end
        check(tag, 32'(side_lamp), 32'(LAMP_GRN));
    endtask

    // Monitor: pop an expected phase on every t_start, check outputs every cycle.
    always @(negedge clk) begin
        if (!reset) begin
            cur = P_RB; first = 1'b1; cyc = 0; prev_start = 1'b0;
        end else begin
            cyc++;
            if (t_start) begin
                check("t_start_width", 32'(prev_start), 32'd0);
                if (!first) check("phase_cycles", 32'(cyc), 32'(prev_len + 2));
                first = 1'b0;
                cyc = 0;
                if (sb_q.size() == 0) check("sb_unexpected_start", 32'd1, 32'd0);
                else cur = sb_q.pop_front();
                prev_len = int'(cur.len);
            end
            check("t_length", 32'(t_length), 32'(cur.len));
            check("main_lamp", 32'(main_lamp), 32'(cur.ml));
            check("side_lamp", 32'(side_lamp), 32'(cur.sl));
            check("ped_walk", 32'(ped_walk), (cur.pm == 2'd2) ? 32'(t_flicker) : 32'(cur.pm[0]));
            prev_start = t_start;
        end
    end

    initial begin
        reset = 1'b0; side_req = 1'b0; ped_req = 1'b0; stale_en = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check("rst_t_start", 32'(t_start), 32'd0);
        check("rst_t_length", 32'(t_length), 32'd2);
        check("rst_main_lamp", 32'(main_lamp), 32'(LAMP_RED));
        check("rst_side_lamp", 32'(side_lamp), 32'(LAMP_RED));
        check("rst_ped_walk", 32'(ped_walk), 32'd0);
        check("rst_side_pend", 32'(dut.side_pend), 32'd0);

        push(P_RB); push(P_MG);
        reset = 1'b1;
        @(posedge clk); #1;
        check("rel_t_start", 32'(t_start), 32'd1);
        check("rel_t_length", 32'(t_length), 32'd2);
        #1;

        // Idle: three MAIN_GO re-entries
        push(P_MG); push(P_MG); push(P_MG);
        wait_drain("idle_drain");

        // Single-cycle side request
        push_side_cycle(); push(P_MG);
        cyc_wait(5);
        side_req = 1'b1; cyc_wait(1); side_req = 1'b0;
        check("side_pend_set", 32'(dut.side_pend), 32'd1);
        wait_side_go("side_go_seen");
        check("side_pend_clr", 32'(dut.side_pend), 32'd0);
        wait_drain("side_drain");

        // Stale done in start and following cycle must be ignored
        stale_en = 1'b1;
        push(P_MG); push(P_MG);
        wait_drain("stale_drain");
        stale_en = 1'b0;

        // Request held across SIDE_GO entry survives the clear
        side_req = 1'b1;
        push_side_cycle(); push(P_MG); push_side_cycle(); push(P_MG);
        wait_side_go("held_side_go");
        check("side_pend_held", 32'(dut.side_pend), 32'd1);
        cyc_wait(1); side_req = 1'b0;
        wait_drain("held_drain");

`ifdef TRAFFIC_CTRL_PED_EN
        push_side_cycle(); push(P_PW); push(P_PF); push(P_MG);
        ped_req = 1'b1; side_req = 1'b1; cyc_wait(1); ped_req = 1'b0; side_req = 1'b0;
        wait_drain("ped_drain");

        ped_req = 1'b1;
        push_side_cycle(); push(P_PW); push(P_PF); push(P_MG);
        push_side_cycle(); push(P_PW); push(P_PF); push(P_MG);
        begin
            int i;
            i = 0;
            while (ped_walk != 1'b1 && i < 200) begin
                @(posedge clk); #2; i++;
            end
        end
        check("walk_seen", 32'(ped_walk), 32'd1);
        check("ped_pend_held", 32'(dut.ped_pend), 32'd1);
        ped_req = 1'b0;
        wait_drain("ped_held_drain");
`else
        push(P_MG);
        ped_req = 1'b1; cyc_wait(1); ped_req = 1'b0;
        wait_drain("ped_off_drain");
        check("ped_off_walk", 32'(ped_walk), 32'd0);
`endif

        // Asynchronous reset in the middle of SIDE_GO
        push(P_MY); push(P_RA); push(P_SG);
        side_req = 1'b1; cyc_wait(1); side_req = 1'b0;
        wait_side_go("rst_side_go");
        cyc_wait(3);
        reset = 1'b0;
        #1;
        check("mid_rst_t_start", 32'(t_start), 32'd0);
        check("mid_rst_t_length", 32'(t_length), 32'd2);
        check("mid_rst_main", 32'(main_lamp), 32'(LAMP_RED));
        check("mid_rst_side", 32'(side_lamp), 32'(LAMP_RED));
        check("mid_rst_walk", 32'(ped_walk), 32'd0);
        check("mid_rst_side_pend", 32'(dut.side_pend), 32'd0);
        sb_q.delete();
        push(P_RB); push(P_MG);
        cyc_wait(2);
        reset = 1'b1;
        @(posedge clk); #1;
        check("rerel_t_start", 32'(t_start), 32'd1);
        check("rerel_t_length", 32'(t_length), 32'd2);
        #1;
        wait_drain("restart_drain");
        check("restart_main", 32'(main_lamp), 32'(LAMP_GRN));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
